// File: rtl/spi_slave_port_if.sv
// Bundle between the SPI slave port, its wire-side master and its controller.
// Carries the SPI pins plus the arm/finished handshake; overrun exists only with SPI_SLAVE_OVERRUN_EN.
interface spi_slave_port_if #(
    parameter int WID = 24
) ();
    logic           sck;
    logic           ss_L;
    logic           mosi;
    logic           miso;
    logic [WID-1:0] to_master;
    logic [WID-1:0] from_master;
    logic           arm;
    logic           finished;
    logic           err;
`ifdef SPI_SLAVE_OVERRUN_EN
    logic           overrun;
`endif

    modport slave (
        input  sck, ss_L, mosi, to_master, arm,
        output miso, from_master, finished, err
`ifdef SPI_SLAVE_OVERRUN_EN
        , output overrun
`endif
    );

    modport master (
        output sck, ss_L, mosi, to_master, arm,
        input  miso, from_master, finished, err
`ifdef SPI_SLAVE_OVERRUN_EN
        , input overrun
`endif
    );
endinterface

// File: rtl/spi_slave_port.sv
// Oversampling SPI responder: shifts one WID-bit word in on MOSI while shifting a preloaded word out on MISO.
// Optional macro SPI_SLAVE_OVERRUN_EN adds the overrun flag for transfers that arrive while not armed.
module spi_slave_port #(
    parameter int WID         = 24,
    parameter int POLARITY    = 0,
    parameter int PHASE       = 0,
    parameter int SYNC_STAGES = 2
) (
    input  logic            clk,
    input  logic            rst_L,
    spi_slave_port_if.slave bus
);
    localparam int         CW       = $clog2(WID + 1);
    localparam logic       CPOL     = (POLARITY != 0);
    localparam logic       CPHA     = (PHASE != 0);
    localparam logic [2:0] IDLE_VEC = {CPOL, 1'b1, 1'b0};

    typedef enum logic [1:0] {IDLE, ARMED, XFER, DONE} state_t;

    // {sck, ss_L, mosi} travel together through the synchronizer chain
    logic [2:0] pin_vec;
    logic [2:0] sync_reg [SYNC_STAGES];
    logic [1:0] dly_reg;

    assign pin_vec = {bus.sck, bus.ss_L, bus.mosi};

    generate
        for (genvar gi = 0; gi < SYNC_STAGES; gi++) begin : g_sync
            if (gi == 0) begin : g_first
                always_ff @(posedge clk) begin
                    if (!rst_L) sync_reg[gi] <= IDLE_VEC;
                    else        sync_reg[gi] <= pin_vec;
                end
            end else begin : g_rest
                always_ff @(posedge clk) begin
                    if (!rst_L) sync_reg[gi] <= IDLE_VEC;
                    else        sync_reg[gi] <= sync_reg[gi-1];
                end
            end
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (!rst_L) dly_reg <= IDLE_VEC[2:1];
        else        dly_reg <= sync_reg[SYNC_STAGES-1][2:1];
    end

    logic sck_sync, ss_sync, mosi_sync;
    logic lead_edge, trail_edge, sample_edge, shift_edge, ss_fall, ss_rise;

    assign sck_sync    = sync_reg[SYNC_STAGES-1][2];
    assign ss_sync     = sync_reg[SYNC_STAGES-1][1];
    assign mosi_sync   = sync_reg[SYNC_STAGES-1][0];
    assign lead_edge   = (sck_sync != CPOL) && (dly_reg[1] == CPOL);
    assign trail_edge  = (sck_sync == CPOL) && (dly_reg[1] != CPOL);
    assign sample_edge = CPHA ? trail_edge : lead_edge;
    assign shift_edge  = CPHA ? lead_edge : trail_edge;
    assign ss_fall     = !ss_sync && dly_reg[0];
    assign ss_rise     = ss_sync && !dly_reg[0];

    state_t         state_reg, state_next;
    logic [WID-1:0] tx_sr_reg, tx_sr_next;
    logic [WID-1:0] rx_sr_reg, rx_sr_next;
    logic [CW-1:0]  cnt_reg, cnt_next;
    logic           miso_reg, miso_next;
    logic           finished_reg, finished_next;
    logic           err_reg, err_next;
    logic [WID-1:0] from_master_reg, from_master_next;
`ifdef SPI_SLAVE_OVERRUN_EN
    logic           overrun_reg, overrun_next;
`endif

    always_ff @(posedge clk) begin
        if (!rst_L) begin
            state_reg       <= IDLE;
            tx_sr_reg       <= '0;
            rx_sr_reg       <= '0;
            cnt_reg         <= '0;
            miso_reg        <= 1'b0;
            finished_reg    <= 1'b0;
            err_reg         <= 1'b0;
            from_master_reg <= '0;
`ifdef SPI_SLAVE_OVERRUN_EN
            overrun_reg     <= 1'b0;
`endif
        end else begin
            state_reg       <= state_next;
            tx_sr_reg       <= tx_sr_next;
            rx_sr_reg       <= rx_sr_next;
            cnt_reg         <= cnt_next;
            miso_reg        <= miso_next;
            finished_reg    <= finished_next;
            err_reg         <= err_next;
            from_master_reg <= from_master_next;
`ifdef SPI_SLAVE_OVERRUN_EN
            overrun_reg     <= overrun_next;
`endif
        end
    end

    always_comb begin
        state_next       = state_reg;
        tx_sr_next       = tx_sr_reg;
        rx_sr_next       = rx_sr_reg;
        cnt_next         = cnt_reg;
        miso_next        = miso_reg;
        finished_next    = finished_reg;
        err_next         = err_reg;
        from_master_next = from_master_reg;
`ifdef SPI_SLAVE_OVERRUN_EN
        overrun_next     = overrun_reg;
`endif
        case (state_reg)
            IDLE: begin
`ifdef SPI_SLAVE_OVERRUN_EN
                if (ss_fall) overrun_next = 1'b1;
`endif
                // Only arm between transfers so we never join one mid-word
                if (bus.arm && ss_sync) begin
                    tx_sr_next = bus.to_master;
                    rx_sr_next = '0;
                    cnt_next   = '0;
                    err_next   = 1'b0;
                    miso_next  = CPHA ? 1'b0 : bus.to_master[WID-1];
                    state_next = ARMED;
`ifdef SPI_SLAVE_OVERRUN_EN
                    overrun_next = 1'b0;
`endif
                end
            end
            ARMED: begin
                if (!bus.arm) begin
                    miso_next  = 1'b0;
                    state_next = IDLE;
                end else if (ss_fall) begin
                    state_next = XFER;
                end
            end
            XFER: begin
                if (sample_edge) begin
                    if (cnt_reg < CW'(WID)) begin
                        rx_sr_next = {rx_sr_reg[WID-2:0], mosi_sync};
                        cnt_next   = cnt_reg + 1'b1;
                    end else begin
                        err_next = 1'b1;
                    end
                end
                if (shift_edge) begin
                    tx_sr_next = tx_sr_reg << 1;
                    miso_next  = CPHA ? tx_sr_reg[WID-1] : tx_sr_reg[WID-2];
                end
                // A coincident sample edge has already been folded into the *_next values
                if (ss_rise) begin
                    from_master_next = rx_sr_next;
                    finished_next    = 1'b1;
                    err_next         = err_next | (cnt_next != CW'(WID));
                    miso_next        = 1'b0;
                    state_next       = DONE;
                end
            end
            DONE: begin
`ifdef SPI_SLAVE_OVERRUN_EN
                if (ss_fall) overrun_next = 1'b1;
`endif
                if (!bus.arm) begin
                    finished_next = 1'b0;
                    state_next    = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    assign bus.miso        = miso_reg;
    assign bus.finished    = finished_reg;
    assign bus.err         = err_reg;
    assign bus.from_master = from_master_reg;
`ifdef SPI_SLAVE_OVERRUN_EN
    assign bus.overrun     = overrun_reg;
`endif
endmodule

// File: tb/tb_spi_slave_port.sv
// Drives a mode-0 and a mode-3 slave with one shared master waveform; both must behave identically.
// Optional macro SPI_SLAVE_OVERRUN_EN enables the unarmed-transfer checks.
module tb_spi_slave_port;
    localparam int S   = 2;
    localparam int BIG = 1 << 30;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_L, sck0, sck3, ss_L, mosi, arm;
    logic [23:0] to_master;

    spi_slave_port_if #(.WID(24)) if0 ();
    spi_slave_port_if #(.WID(24)) if3 ();

    assign if0.sck = sck0;      assign if3.sck = sck3;
    assign if0.ss_L = ss_L;     assign if3.ss_L = ss_L;
    assign if0.mosi = mosi;     assign if3.mosi = mosi;
    assign if0.arm = arm;       assign if3.arm = arm;
    assign if0.to_master = to_master;
    assign if3.to_master = to_master;

    spi_slave_port #(.WID(24), .POLARITY(0), .PHASE(0), .SYNC_STAGES(S)) dut0 (
        .clk(clk), .rst_L(rst_L), .bus(if0.slave));
    spi_slave_port #(.WID(24), .POLARITY(1), .PHASE(1), .SYNC_STAGES(S)) dut3 (
        .clk(clk), .rst_L(rst_L), .bus(if3.slave));

    int checks = 0;
    int errors = 0;
    int cyc    = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Model: word expected after the last tracked transfer and the cycle window where finished must be high
    logic [23:0] exp_from = '0;
    logic        exp_err  = 1'b0;
    int          fin_from  = BIG;
    int          fin_until = BIG;
    bit          mon_on    = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    always @(negedge clk) begin
        if (mon_on) begin
            logic exp_fin;
            exp_fin = (cyc >= fin_from) && (cyc < fin_until);
            chk("finished0", {31'd0, if0.finished}, {31'd0, exp_fin});
            chk("finished3", {31'd0, if3.finished}, {31'd0, exp_fin});
            if (exp_fin) begin
                chk("from_master0", {8'd0, if0.from_master}, {8'd0, exp_from});
                chk("from_master3", {8'd0, if3.from_master}, {8'd0, exp_from});
                chk("err0", {31'd0, if0.err}, {31'd0, exp_err});
                chk("err3", {31'd0, if3.err}, {31'd0, exp_err});
            end
        end
    end

    task automatic wait_clk(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic start_xfer(input logic [31:0] word, input int n, input bit track);
        if (track) begin
            exp_from  = (n >= 24) ? word[31:8] : 24'(word >> (32 - n));
            exp_err   = (n != 24);
            fin_from  = BIG;
            fin_until = BIG;
        end
        ss_L = 1'b0;
        wait_clk(8);
    endtask

    // Both modes sample on the rising edge; mode 3 shifts on the preceding fall, mode 0 on the following fall
    task automatic send_bits(input logic [31:0] word, input int n, input logic [23:0] tx_exp, input bit chk_miso);
        for (int i = 0; i < n; i++) begin
            mosi = word[31-i];
            sck3 = 1'b0;
            wait_clk(8);
            if (chk_miso && i < 24) begin
                chk("miso0", {31'd0, if0.miso}, {31'd0, tx_exp[23-i]});
                chk("miso3", {31'd0, if3.miso}, {31'd0, tx_exp[23-i]});
            end
            sck0 = 1'b1;
            sck3 = 1'b1;
            wait_clk(8);
            sck0 = 1'b0;
            wait_clk(8);
        end
    endtask

    task automatic end_xfer(input bit track);
        int k;
        wait_clk(8);
        ss_L = 1'b1;
        if (track) begin
            fin_from = cyc + S + 1;
            k = 0;
            while (!if0.finished && k < 20) begin
                wait_clk(1);
                k++;
            end
            chk("finish_latency", k, S + 1);
        end
        wait_clk(6);
    endtask

    task automatic drop_arm();
        arm = 1'b0;
        fin_until = cyc + 1;
        wait_clk(4);
    endtask

    task automatic arm_with(input logic [23:0] w);
        to_master = w;
        arm = 1'b1;
        wait_clk(6);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1);
    end

    initial begin
        rst_L = 1'b0; sck0 = 1'b0; sck3 = 1'b1; ss_L = 1'b1; mosi = 1'b0; arm = 1'b0;
        to_master = '0;
        wait_clk(4);
        chk("rst_miso0", {31'd0, if0.miso}, 32'd0);
        chk("rst_finished0", {31'd0, if0.finished}, 32'd0);
        chk("rst_err3", {31'd0, if3.err}, 32'd0);
        chk("rst_from3", {8'd0, if3.from_master}, 32'd0);
        rst_L = 1'b1;
        mon_on = 1'b1;
        wait_clk(4);

        // Nominal 24-bit transfer
        arm_with(24'hA5C3F0);
        chk("armed_miso0", {31'd0, if0.miso}, 32'd1);
        chk("armed_miso3", {31'd0, if3.miso}, 32'd0);
        start_xfer(32'h12345600, 24, 1'b1);
        send_bits(32'h12345600, 24, 24'hA5C3F0, 1'b1);
        end_xfer(1'b1);
        chk("nominal_from", {8'd0, if0.from_master}, 32'h123456);
        chk("nominal_err", {31'd0, if3.err}, 32'd0);
        $display("xfer nominal from_master=%h err=%0d", if0.from_master, if0.err);
        drop_arm();
        chk("disarm_finished", {31'd0, if0.finished}, 32'd0);

        // Short transfer: 20 bits
        arm_with(24'h0F1E2D);
        start_xfer(32'h12345678, 20, 1'b1);
        send_bits(32'h12345678, 20, 24'h0F1E2D, 1'b1);
        end_xfer(1'b1);
        chk("short_from", {8'd0, if0.from_master}, 32'h012345);
        chk("short_err", {31'd0, if0.err}, 32'd1);
        $display("xfer short from_master=%h err=%0d", if0.from_master, if0.err);
        drop_arm();

        // Long transfer: 28 bits, only the first 24 kept
        arm_with(24'h5AA55A);
        start_xfer(32'hABCDEF12, 28, 1'b1);
        send_bits(32'hABCDEF12, 28, 24'h5AA55A, 1'b1);
        end_xfer(1'b1);
        chk("long_from", {8'd0, if3.from_master}, 32'hABCDEF);
        chk("long_err", {31'd0, if3.err}, 32'd1);
        $display("xfer long from_master=%h err=%0d", if3.from_master, if3.err);
        drop_arm();

        // Reset after 10 bits, then a fresh all-ones word
        arm_with(24'h5A5A5A);
        start_xfer(32'h00000000, 10, 1'b0);
        send_bits(32'h00000000, 10, 24'h5A5A5A, 1'b1);
        rst_L = 1'b0;
        arm = 1'b0;
        wait_clk(3);
        rst_L = 1'b1;
        wait_clk(2);
        chk("midrst_from", {8'd0, if0.from_master}, 32'd0);
        chk("midrst_miso", {31'd0, if0.miso}, 32'd0);
        ss_L = 1'b1;
        wait_clk(8);
        arm_with(24'h3C3C3C);
        start_xfer(32'hFFFFFF00, 24, 1'b1);
        send_bits(32'hFFFFFF00, 24, 24'h3C3C3C, 1'b1);
        end_xfer(1'b1);
        chk("postrst_from", {8'd0, if0.from_master}, 32'hFFFFFF);
        chk("postrst_err", {31'd0, if0.err}, 32'd0);
        $display("xfer after reset from_master=%h err=%0d", if0.from_master, if0.err);

`ifdef SPI_SLAVE_OVERRUN_EN
        // Transfer while DONE with arm still held: flagged, ignored, miso stays low
        chk("pre_overrun", {31'd0, if0.overrun}, 32'd0);
        start_xfer(32'h0F0F0F00, 24, 1'b0);
        send_bits(32'h0F0F0F00, 24, 24'h000000, 1'b1);
        end_xfer(1'b0);
        chk("overrun0", {31'd0, if0.overrun}, 32'd1);
        chk("overrun3", {31'd0, if3.overrun}, 32'd1);
        chk("overrun_from", {8'd0, if0.from_master}, 32'hFFFFFF);
        $display("xfer unarmed overrun=%0d from_master=%h", if0.overrun, if0.from_master);
        drop_arm();
        arm_with(24'h000001);
        chk("rearm_overrun0", {31'd0, if0.overrun}, 32'd0);
        chk("rearm_overrun3", {31'd0, if3.overrun}, 32'd0);
`endif
        drop_arm();
        wait_clk(4);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
